mdio_phy_slave: RTL

MDIO_PHY_SLAVE -- requirements
Module: mdio_phy_slave

---
 rtl/mdio_phy_slave.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mdio_phy_slave.sv
// rtl/mdio_phy_slave.sv - MDIO PHY-side management slave with register strobe interface
// Optional MDIO_PREAMBLE_CHECK_EN: require 32 sampled preamble ones before the ST bit.
module mdio_phy_slave #(
  parameter logic [4:0]  PHY_ADDR   = 5'd1,
  parameter int          REG_COUNT  = 32,
  parameter logic [15:0] RD_INVALID = 16'hFFFF
) (
  input  logic        MDC,
  input  logic        RESET,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic        MDIO_IN_OE,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_STB,
  output logic        MDIO_DONE
);

  typedef enum logic [2:0] {IDLE, HDR, W_TA, W_DATA, R_TA, R_DATA, SKIP} state_t;

  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [12:0] hdr_sh;
  logic [15:0] data_sh;
  logic [4:0]  reg_addr;
  logic        reg_bad;
`ifdef MDIO_PREAMBLE_CHECK_EN
  logic [5:0]  pre_cnt;
`endif

  // Header including the bit on the wire this edge, so decode happens on the 14th edge itself.
  logic [13:0] hdr_full;
  logic [1:0]  hdr_st;
  logic [1:0]  hdr_op;
  logic [4:0]  hdr_phy;
  logic [4:0]  hdr_reg;
  logic        hdr_ok;
  logic        hdr_reg_bad;

  assign hdr_full    = {hdr_sh, MDIO_OUT};
  assign hdr_st      = hdr_full[13:12];
  assign hdr_op      = hdr_full[11:10];
  assign hdr_phy     = hdr_full[9:5];
  assign hdr_reg     = hdr_full[4:0];
  assign hdr_ok      = (hdr_st == 2'b01) && ((hdr_op == 2'b01) || (hdr_op == 2'b10)) &&
                       (hdr_phy == PHY_ADDR);
  assign hdr_reg_bad = ({1'b0, hdr_reg} >= REG_LIMIT);

  always_ff @(posedge MDC) begin
    if (!RESET) begin
      state      <= IDLE;
      bit_cnt    <= 5'd0;
      hdr_sh     <= 13'd0;
      data_sh    <= 16'd0;
      reg_addr   <= 5'd0;
      reg_bad    <= 1'b0;
      MDIO_IN    <= 1'b0;
      MDIO_IN_OE <= 1'b0;
      ADDR       <= 5'd0;
      WR_DATA    <= 16'd0;
      WR_STB     <= 1'b0;
      RD_STB     <= 1'b0;
      MDIO_DONE  <= 1'b0;
`ifdef MDIO_PREAMBLE_CHECK_EN
      pre_cnt    <= 6'd0;
`endif
    end else begin
      WR_STB    <= 1'b0;
      RD_STB    <= 1'b0;
      MDIO_DONE <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MDIO_PREAMBLE_CHECK_EN
          if (!MDIO_OE) begin
            pre_cnt <= 6'd0;
          end else if (MDIO_OUT) begin
            if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
          end else begin
            pre_cnt <= 6'd0;
            if (pre_cnt == 6'd32) begin
              state   <= HDR;
              bit_cnt <= 5'd1;
              hdr_sh  <= 13'd0;
            end
          end
`else
          if (MDIO_OE && !MDIO_OUT) begin
            state   <= HDR;
            bit_cnt <= 5'd1;
            hdr_sh  <= 13'd0;
          end
`endif
        end

        HDR: begin
          if (!MDIO_OE) begin
            state   <= IDLE;
            bit_cnt <= 5'd0;
          end else if (bit_cnt == 5'd13) begin
            bit_cnt  <= 5'd0;
            reg_addr <= hdr_reg;
            reg_bad  <= hdr_reg_bad;
            if (!hdr_ok) begin
              state <= SKIP;
            end else if (hdr_op == 2'b01) begin
              state <= W_TA;
            end else begin
              state  <= R_TA;
              ADDR   <= hdr_reg;
              RD_STB <= 1'b1;
            end
          end else begin
            hdr_sh  <= hdr_full[12:0];
            bit_cnt <= bit_cnt + 5'd1;
          end
        end

        W_TA: begin
          if (!MDIO_OE) begin
            state   <= IDLE;
            bit_cnt <= 5'd0;
          end else if (bit_cnt == 5'd1) begin
            state   <= W_DATA;
            bit_cnt <= 5'd0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end

        W_DATA: begin
          if (!MDIO_OE) begin
            state   <= IDLE;
            bit_cnt <= 5'd0;
          end else if (bit_cnt == 5'd15) begin
            // Out-of-range writes are consumed silently; the user side keeps its last access.
            if (!reg_bad) begin
              ADDR    <= reg_addr;
              WR_DATA <= {data_sh[14:0], MDIO_OUT};
              WR_STB  <= 1'b1;
            end
            MDIO_DONE <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= 5'd0;
          end else begin
            data_sh <= {data_sh[14:0], MDIO_OUT};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end

        R_TA: begin
          data_sh    <= reg_bad ? RD_INVALID : RD_DATA;
          MDIO_IN_OE <= 1'b1;
          MDIO_IN    <= 1'b0;
          state      <= R_DATA;
          bit_cnt    <= 5'd0;
        end

        R_DATA: begin
          if (bit_cnt == 5'd16) begin
            MDIO_IN_OE <= 1'b0;
            MDIO_IN    <= 1'b0;
            MDIO_DONE  <= 1'b1;
            state      <= IDLE;
            bit_cnt    <= 5'd0;
          end else begin
            MDIO_IN <= data_sh[15];
            data_sh <= {data_sh[14:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end

        SKIP: begin
          if (bit_cnt == 5'd17) begin
            state   <= IDLE;
            bit_cnt <= 5'd0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= 5'd0;
        end
      endcase
    end
  end

endmodule
